// File: rtl/rnn_pkg.sv
// Shared definitions for the matvec engine: register map, CTRL bit
// positions and the sequencing FSM state encoding.
package rnn_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_VEC    = 3'd1;
  localparam logic [2:0] ADDR_MAT    = 3'd2;
  localparam logic [2:0] ADDR_BIAS   = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;
  localparam logic [2:0] ADDR_RSEL   = 3'd5;

  localparam int CTRL_START   = 0;
  localparam int CTRL_RELU    = 1;
  localparam int CTRL_CLR_ERR = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_WB,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mac_sat.sv
// Signed multiply-accumulate with fixed-point rescale, bias add,
// saturation to DATA_W bits and optional ReLU.
module mac_sat #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 37
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] mat_elem,
  input  logic signed [DATA_W-1:0] vec_elem,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     relu_en,
  output logic signed [DATA_W-1:0] result
);

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [ACC_W:0]      sum;
  logic signed [ACC_W:0]      sat_val;

  assign product = mat_elem * vec_elem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of block ordering.
      acc <= acc + ACC_W'(product);
    end
  end

  // One extra bit on the sum so the bias add can never wrap before clamping.
  assign shifted = acc >>> FRAC_W;
  assign sum     = (ACC_W+1)'(shifted) + (ACC_W+1)'(bias);

  always_comb begin
    // NOTE: defaults first keeps this block free of inferred latches.
    sat_val = sum;
    if (sum > SAT_MAX) begin
      sat_val = SAT_MAX;
    end else if (sum < SAT_MIN) begin
      sat_val = SAT_MIN;
    end
    result = sat_val[DATA_W-1:0];
    if (relu_en && sat_val[DATA_W-1]) begin
      result = '0;
    end
  end

endmodule

// File: rtl/matvec_engine.sv
// Register-mapped fixed-point matrix-vector engine: y = sat(M*v >>> FRAC_W + b),
// one product per cycle, with optional ReLU.
module matvec_engine
  import rnn_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 32,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int ACC_W  = 2 * DATA_W + $clog2(COLS);
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RIDX_W-1:0] ROW_LAST = RIDX_W'(ROWS - 1);
  localparam logic [CIDX_W-1:0] COL_LAST = CIDX_W'(COLS - 1);

  logic signed [DATA_W-1:0] vec_mem  [COLS];
  logic signed [DATA_W-1:0] mat_mem  [ROWS][COLS];
  logic signed [DATA_W-1:0] bias_mem [ROWS];
  logic signed [DATA_W-1:0] y_mem    [ROWS];

  state_t                   state, state_next;
  logic [RIDX_W-1:0]        row, rsel;
  logic [CIDX_W-1:0]        col;
  logic                     busy, done, err, relu_en;
  logic                     acc_clr, acc_en, y_we;
  logic signed [DATA_W-1:0] mac_result;

  logic [2:0] reg_sel;
  logic       wr_ctrl, wr_vec, wr_mat, wr_bias, wr_rsel;
  logic       vec_ok, mat_ok, bias_ok, rsel_ok;
  logic       start_ok, clr_err, err_set;
  logic       unused_bits;

  assign reg_sel     = addr[2:0];
  assign unused_bits = ^{addr[31:3], data_in};

  assign wr_ctrl = write && (reg_sel == ADDR_CTRL);
  assign wr_vec  = write && (reg_sel == ADDR_VEC);
  assign wr_mat  = write && (reg_sel == ADDR_MAT);
  assign wr_bias = write && (reg_sel == ADDR_BIAS);
  assign wr_rsel = write && (reg_sel == ADDR_RSEL);

  assign vec_ok  = data_in[31:16] < 16'(COLS);
  assign mat_ok  = (data_in[31:24] < 8'(ROWS)) && (data_in[23:16] < 8'(COLS));
  assign bias_ok = data_in[31:16] < 16'(ROWS);
  assign rsel_ok = data_in < 32'(ROWS);

  assign start_ok = wr_ctrl && data_in[CTRL_START] && !busy;
  assign clr_err  = wr_ctrl && data_in[CTRL_CLR_ERR];
  assign err_set  = (wr_vec  && (!vec_ok  || busy)) ||
                    (wr_mat  && (!mat_ok  || busy)) ||
                    (wr_bias && (!bias_ok || busy)) ||
                    (wr_rsel && !rsel_ok);

  // NOTE: operand storage has no reset; it is pure data, and its contents must
  // survive a reset that aborts a computation.
  always_ff @(posedge clk) begin
    if (wr_vec && vec_ok && !busy) begin
      vec_mem[data_in[16 +: CIDX_W]] <= data_in[DATA_W-1:0];
    end
    if (wr_mat && mat_ok && !busy) begin
      mat_mem[data_in[24 +: RIDX_W]][data_in[16 +: CIDX_W]] <= data_in[DATA_W-1:0];
    end
    if (wr_bias && bias_ok && !busy) begin
      bias_mem[data_in[16 +: RIDX_W]] <= data_in[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    y_we       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_next = ST_MAC;
          acc_clr    = 1'b1;
        end
      end
      ST_MAC: begin
        acc_en = 1'b1;
        if (col == COL_LAST) begin
          state_next = ST_WB;
        end
      end
      ST_WB: begin
        y_we       = 1'b1;
        acc_clr    = 1'b1;
        state_next = (row == ROW_LAST) ? ST_DONE : ST_MAC;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      relu_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            row     <= '0;
            col     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            relu_en <= data_in[CTRL_RELU];
          end
        end
        ST_MAC: col <= (col == COL_LAST) ? '0 : col + 1'b1;
        ST_WB: begin
          if (row != ROW_LAST) begin
            row <= row + 1'b1;
          end
        end
        ST_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Error sources and the clear bit live at different addresses, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err  <= 1'b0;
      rsel <= '0;
    end else begin
      if (err_set) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
      if (wr_rsel && rsel_ok) begin
        rsel <= data_in[RIDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) begin
        y_mem[i] <= '0;
      end
    end else if (y_we) begin
      y_mem[row] <= mac_result;
    end
  end

  // Reads sample pre-edge state, so a same-cycle write is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (read) begin
      case (reg_sel)
        ADDR_CTRL:   data_out <= {29'b0, err, done, busy};
        ADDR_RESULT: data_out <= 32'(y_mem[rsel]);
        ADDR_RSEL:   data_out <= 32'(rsel);
        default:     data_out <= '0;
      endcase
    end
  end

  mac_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .en       (acc_en),
    .mat_elem (mat_mem[row][col]),
    .vec_elem (vec_mem[col]),
    .bias     (bias_mem[row]),
    .relu_en  (relu_en),
    .result   (mac_result)
  );

endmodule

// File: tb/tb_matvec_engine.sv
// Self-checking bench for matvec_engine: register-level stimulus compared
// against an array-based arithmetic model of y = sat(M*v/2^FRAC_W + b).
module tb_matvec_engine;

  localparam int ROWS   = 4;
  localparam int COLS   = 32;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  localparam logic [2:0] A_CTRL = 3'd0, A_VEC = 3'd1, A_MAT = 3'd2;
  localparam logic [2:0] A_BIAS = 3'd3, A_RESULT = 3'd4, A_RSEL = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;

  int checks = 0;
  int errors = 0;

  int mv [COLS];
  int mm [ROWS][COLS];
  int mb [ROWS];

  matvec_engine #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected output of one row, straight from the arithmetic definition.
  function automatic int exp_y(input int r, input bit relu);
    longint acc = 0;
    for (int c = 0; c < COLS; c++) acc += longint'(mm[r][c]) * longint'(mv[c]);
    acc = (acc >>> FRAC_W) + longint'(mb[r]);
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return int'(acc);
  endfunction

  // Bus tasks start and end on a falling edge; each takes one clock.
  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    write = 1'b1; addr = {29'b0, a}; data_in = d;
    @(posedge clk);
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    read = 1'b1; addr = {29'b0, a};
    @(posedge clk);
    @(negedge clk);
    read = 1'b0;
    d = data_out;
  endtask

  task automatic reg_rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] rd);
    read = 1'b1; write = 1'b1; addr = {29'b0, a}; data_in = wd;
    @(posedge clk);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    rd = data_out;
  endtask

  task automatic set_vec(input int i, input int val);
    logic [15:0] idx = 16'(i);
    logic [15:0] v16 = 16'(val);
    reg_write(A_VEC, {idx, v16});
    mv[i] = val;
  endtask

  task automatic set_mat(input int r, input int c, input int val);
    logic [7:0]  ri = 8'(r);
    logic [7:0]  ci = 8'(c);
    logic [15:0] v16 = 16'(val);
    reg_write(A_MAT, {ri, ci, v16});
    mm[r][c] = val;
  endtask

  task automatic set_bias(input int r, input int val);
    logic [15:0] idx = 16'(r);
    logic [15:0] v16 = 16'(val);
    reg_write(A_BIAS, {idx, v16});
    mb[r] = val;
  endtask

  task automatic load_all(input bit rnd);
    for (int c = 0; c < COLS; c++) set_vec(c, rnd ? int'($urandom_range(0, 65535)) - 32768 : 0);
    for (int r = 0; r < ROWS; r++) begin
      set_bias(r, rnd ? int'($urandom_range(0, 65535)) - 32768 : 0);
      for (int c = 0; c < COLS; c++)
        set_mat(r, c, rnd ? int'($urandom_range(0, 65535)) - 32768 : 0);
    end
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] st;
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      reg_read(A_CTRL, st);
      if (st[1]) seen = 1;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic check_results(input string tag, input bit relu);
    logic [31:0] got;
    for (int r = 0; r < ROWS; r++) begin
      reg_write(A_RSEL, 32'(r));
      reg_read(A_RESULT, got);
      check($sformatf("%s_y%0d", tag, r), got, 32'(exp_y(r, relu)));
    end
  endtask

  task automatic run(input string tag, input bit relu);
    reg_write(A_CTRL, relu ? 32'h3 : 32'h1);
    wait_done(tag);
    check_results(tag, relu);
  endtask

  task automatic load_basic();
    load_all(0);
    set_vec(0, 256);
    set_mat(0, 0, 512);
    set_bias(0, -128);
  endtask

  logic [31:0] got;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    reg_read(A_CTRL, got);
    check("reset_ctrl", got, 32'h0);
    reg_read(A_RESULT, got);
    check("reset_result", got, 32'h0);

    // Basic case with exact latency: done rises on the 133rd edge after start.
    load_basic();
    reg_write(A_CTRL, 32'h1);
    repeat (ROWS * (COLS + 1)) @(negedge clk);
    reg_read(A_CTRL, got);
    check("latency_busy", got, 32'h1);
    reg_read(A_CTRL, got);
    check("latency_done", got, 32'h2);
    check_results("basic", 0);
    reg_write(A_RSEL, 32'd0);
    reg_read(A_RESULT, got);
    check("basic_y0_384", got, 32'd384);

    // Randomized operand sets, with and without ReLU.
    for (int it = 0; it < 4; it++) begin
      load_all(1);
      run($sformatf("rand%0d", it), it[0]);
    end

    // Saturation at both ends.
    for (int c = 0; c < COLS; c++) begin
      set_vec(c, 32767);
      set_mat(1, c, 32767);
    end
    run("sat_pos", 0);
    reg_write(A_RSEL, 32'd1);
    reg_read(A_RESULT, got);
    check("sat_pos_y1", got, 32'h0000_7FFF);
    for (int c = 0; c < COLS; c++) set_mat(1, c, -32768);
    run("sat_neg", 0);
    reg_write(A_RSEL, 32'd1);
    reg_read(A_RESULT, got);
    check("sat_neg_y1", got, 32'hFFFF_8000);

    // ReLU latched per start.
    load_all(0);
    set_bias(0, -128);
    run("relu_on", 1);
    run("relu_off", 0);

    // Out-of-range MAT row: dropped and flagged; read/write same cycle sees old err.
    reg_write(A_MAT, {8'd4, 8'd0, 16'h1234});
    reg_read(A_CTRL, got);
    check("mat_oob_err", got, 32'h6);
    reg_rw(A_CTRL, 32'h4, got);
    check("rw_pre_write", got, 32'h6);
    reg_read(A_CTRL, got);
    check("err_cleared", got, 32'h2);

    // Out-of-range RSEL: flagged, selection unchanged.
    reg_write(A_RSEL, 32'd0);
    reg_write(A_RSEL, 32'd4);
    reg_read(A_RESULT, got);
    check("rsel_oob_keep", got, 32'(exp_y(0, 0)));
    reg_read(A_CTRL, got);
    check("rsel_oob_err", got, 32'h6);
    reg_write(A_CTRL, 32'h4);

    // Unmapped address reads zero.
    reg_write(3'd6, 32'hDEAD_BEEF);
    reg_read(3'd6, got);
    check("unmapped_read", got, 32'h0);

    // Writes and a second start while busy.
    load_all(1);
    reg_write(A_CTRL, 32'h1);
    reg_write(A_CTRL, 32'h1);
    reg_read(A_CTRL, got);
    check("start_busy_no_err", got, 32'h1);
    reg_write(A_VEC, {16'd0, 16'h1234});
    reg_read(A_CTRL, got);
    check("vec_busy_err", got, 32'h5);
    wait_done("busy_wr");
    check_results("busy_wr", 0);
    reg_write(A_CTRL, 32'h4);

    // Reset mid-MAC: outputs clear at once, operands survive.
    load_basic();
    reg_write(A_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    reg_read(A_CTRL, got);
    check("pre_rst_busy", got, 32'h1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_dout", data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    reg_read(A_CTRL, got);
    check("rst_ctrl", got, 32'h0);
    for (int r = 0; r < ROWS; r++) begin
      reg_write(A_RSEL, 32'(r));
      reg_read(A_RESULT, got);
      check($sformatf("rst_y%0d", r), got, 32'h0);
    end
    run("after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
